// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(8,4) SECDED link: codeword layout,
// encoder function and the syndrome map used by the decoder side.
package hamming_pkg;

    localparam int NIBBLES = 16;
    localparam int CW_W    = 8;

    // Bit i of a codeword is Hamming position i; bit 0 carries overall parity.
    localparam int POS_PAR = 0;
    localparam int POS_P1  = 1;
    localparam int POS_P2  = 2;
    localparam int POS_D1  = 3;
    localparam int POS_P4  = 4;
    localparam int POS_D2  = 5;
    localparam int POS_D3  = 6;
    localparam int POS_D4  = 7;

    typedef enum logic {
        IDLE,
        SEND
    } enc_state_t;

    typedef enum logic [1:0] {
        CW_OK,
        CW_SINGLE,
        CW_PARITY_ONLY,
        CW_DOUBLE
    } err_class_t;

    function automatic logic [CW_W-1:0] encode84(input logic [3:0] nib);
        logic [CW_W-1:0] cw;
        cw          = '0;
        cw[POS_D1]  = nib[0];
        cw[POS_D2]  = nib[1];
        cw[POS_D3]  = nib[2];
        cw[POS_D4]  = nib[3];
        cw[POS_P1]  = nib[0] ^ nib[1] ^ nib[3];
        cw[POS_P2]  = nib[0] ^ nib[2] ^ nib[3];
        cw[POS_P4]  = nib[1] ^ nib[2] ^ nib[3];
        cw[POS_PAR] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    // Syndrome value equals the Hamming position of a single flipped bit (0 = none).
    function automatic logic [2:0] syndrome84(input logic [CW_W-1:0] cw);
        logic [2:0] s;
        s[0] = cw[POS_P1] ^ cw[POS_D1] ^ cw[POS_D2] ^ cw[POS_D4];
        s[1] = cw[POS_P2] ^ cw[POS_D1] ^ cw[POS_D3] ^ cw[POS_D4];
        s[2] = cw[POS_P4] ^ cw[POS_D2] ^ cw[POS_D3] ^ cw[POS_D4];
        return s;
    endfunction

    function automatic err_class_t classify84(input logic [CW_W-1:0] cw);
        logic [2:0] s;
        logic       odd;
        s   = syndrome84(cw);
        odd = ^cw;
        if (s == 3'd0 && !odd) return CW_OK;
        if (s == 3'd0 &&  odd) return CW_PARITY_ONLY;
        if (odd)               return CW_SINGLE;
        return CW_DOUBLE;
    endfunction

endpackage

// File: rtl/hamming_frame_encoder_if.sv
// Message-in / codeword-out stream bundle of the frame encoder.
// master = upstream + downstream environment, slave = the encoder.
interface hamming_frame_encoder_if #(
    parameter int NIBBLES = 16
);
    localparam int IDX_W = $clog2(NIBBLES);

    logic                   in_valid;
    logic                   in_ready;
    logic [4*NIBBLES-1:0]   in_message;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;

    modport master (
        output in_valid, in_message, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_message, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/hamming84_enc.sv
// Combinational Hamming(8,4) SECDED encoder: one nibble in, one codeword out.
module hamming84_enc
    import hamming_pkg::*;
(
    input  logic [3:0]      nib,
    output logic [CW_W-1:0] cw
);

    assign cw = encode84(nib);

endmodule

// File: rtl/hamming_frame_encoder.sv
// Frame encoder: accepts a message, streams one SECDED codeword per nibble,
// and counts completed frames. Back-to-back frames run without a bubble.
module hamming_frame_encoder #(
    parameter int NIBBLES = 16,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hamming_frame_encoder_if.slave  bus,
    output logic [CNT_W-1:0]        frames_sent
);
    import hamming_pkg::*;

    localparam int                MSG_W    = 4 * NIBBLES;
    localparam int                IDX_W    = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    enc_state_t         state;
    logic [MSG_W-1:0]   msg_q;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   next_cnt;
    logic               fire;
    logic               accept;
    logic [3:0]         nib_sel;
    logic [CW_W-1:0]    cw_next;

    assign fire         = bus.out_valid && bus.out_ready;
    assign bus.in_ready = (state == IDLE) || (fire && bus.out_last);
    assign accept       = bus.in_valid && bus.in_ready;
    assign next_cnt     = cnt + IDX_W'(1);
    assign bus.out_idx  = cnt;

    // The single encoder looks one codeword ahead: nibble 0 of the incoming
    // message on acceptance, otherwise the next nibble of the held message.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nib_sel = '0;
        if (accept) begin
            nib_sel = bus.in_message[3:0];
        end else begin
            nib_sel = msg_q[4*next_cnt +: 4];
        end
    end

    hamming84_enc u_enc (
        .nib (nib_sel),
        .cw  (cw_next)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            // NOTE: msg_q is a plain register, not a memory, so it is reset with the rest for a clean restart.
            msg_q         <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            frames_sent   <= '0;
        end else begin
            if (fire && bus.out_last) begin
                frames_sent <= frames_sent + CNT_W'(1);
            end

            if (accept) begin
                state         <= SEND;
                msg_q         <= bus.in_message;
                cnt           <= '0;
                bus.out_valid <= 1'b1;
                bus.out_data  <= cw_next;
                bus.out_last  <= (LAST_IDX == '0);
            end else if (fire) begin
                if (bus.out_last) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                end else begin
                    cnt          <= next_cnt;
                    bus.out_data <= cw_next;
                    bus.out_last <= (next_cnt == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// Self-checking bench for hamming_frame_encoder against a position-based
// Hamming reference model and a byte-stream scoreboard.
module tb_hamming_frame_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hamming_frame_encoder_if #(.NIBBLES(16)) bus  ();
    hamming_frame_encoder_if #(.NIBBLES(16)) wbus ();

    logic [15:0] frames_sent;
    logic [1:0]  frames_w;

    hamming_frame_encoder #(.NIBBLES(16), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .frames_sent (frames_sent)
    );

    hamming_frame_encoder #(.NIBBLES(16), .CNT_W(2)) dut_w (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (wbus),
        .frames_sent (frames_w)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] tx_msgs[$];
    logic [7:0]  got_data[$];
    logic [3:0]  got_idx[$];
    logic        got_last[$];
    int          got_cyc[$];
    int          acc_cyc[$];
    logic [12:0] exp_word[$];
    int          stall_changes;
    bit          timed_out;

    // Reference: data at positions 3,5,6,7; check bit 2^j covers every
    // position with bit j set; bit 0 makes the weight even.
    function automatic logic [7:0] ref_encode(input logic [3:0] nib);
        int         data_pos[4];
        logic [7:0] cw;
        logic       p;
        data_pos[0] = 3; data_pos[1] = 5; data_pos[2] = 6; data_pos[3] = 7;
        cw = 8'h00;
        for (int k = 0; k < 4; k++) cw[data_pos[k]] = nib[k];
        for (int j = 0; j < 3; j++) begin
            p = 1'b0;
            for (int pos = 1; pos < 8; pos++)
                if (pos != (1 << j) && (pos & (1 << j)) != 0) p ^= cw[pos];
            cw[1 << j] = p;
        end
        cw[0] = ^cw[7:1];
        return cw;
    endfunction

    function automatic logic [3:0] ref_syndrome(input logic [7:0] cw);
        logic [2:0] s = 3'd0;
        for (int pos = 1; pos < 8; pos++)
            if (cw[pos]) s ^= 3'(pos);
        return {^cw, s};
    endfunction

    function automatic void build_expected();
        logic [63:0] m;
        exp_word.delete();
        foreach (tx_msgs[f]) begin
            m = tx_msgs[f];
            for (int k = 0; k < 16; k++)
                exp_word.push_back({ref_encode(m[4*k +: 4]), 4'(k), (k == 15)});
        end
    endfunction

    // Drives tx_msgs (each held valid until taken) and logs every handshake.
    task automatic run_stream(input int ready_pct);
        int         j = 0;
        int         cyc = 0;
        int         total;
        bit         prev_stall = 1'b0;
        logic [7:0] pd;
        logic [3:0] pi;
        logic       pl;
        got_data.delete(); got_idx.delete(); got_last.delete();
        got_cyc.delete();  acc_cyc.delete();
        stall_changes = 0;
        total = 16 * tx_msgs.size();
        @(negedge clk);
        while (got_data.size() < total && cyc < 4000) begin
            bus.in_valid   = (j < tx_msgs.size());
            bus.in_message = (j < tx_msgs.size()) ? tx_msgs[j] : 64'h0;
            bus.out_ready  = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== pd ||
                               bus.out_idx !== pi || bus.out_last !== pl))
                stall_changes++;
            prev_stall = bus.out_valid && !bus.out_ready;
            pd = bus.out_data; pi = bus.out_idx; pl = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_idx.push_back(bus.out_idx);
                got_last.push_back(bus.out_last);
                got_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc.push_back(cyc);
                j++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        timed_out = (got_data.size() < total);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        n_cmp++; if (bus.out_idx !== 4'd0) begin n_bad++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL reset_frames_sent: got %0d want 0", frames_sent); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        tx_msgs = '{64'h0123456789ABCDEF};
        build_expected();
        run_stream(100);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got %0d bytes want 16", got_data.size()); end
        for (int k = 0; k < exp_word.size(); k++) begin
            logic [12:0] obs = (k < got_data.size()) ? {got_data[k], got_idx[k], got_last[k]} : 13'bx;
            n_cmp++;
            if (obs !== exp_word[k]) begin
                n_bad++;
                $display("FAIL single_byte %0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         k, obs[12:5], obs[4:1], obs[0], exp_word[k][12:5], exp_word[k][4:1], exp_word[k][0]);
            end
        end
        if (got_data.size() >= 16) begin
            n_cmp++; if (got_data[0]  !== 8'hFF) begin n_bad++; $display("FAIL single_idx0: got %h want FF", got_data[0]); end
            n_cmp++; if (got_data[1]  !== 8'hF0) begin n_bad++; $display("FAIL single_idx1: got %h want F0", got_data[1]); end
            n_cmp++; if (got_data[14] !== 8'h0F) begin n_bad++; $display("FAIL single_idx14: got %h want 0F", got_data[14]); end
            n_cmp++; if (got_data[15] !== 8'h00) begin n_bad++; $display("FAIL single_idx15: got %h want 00", got_data[15]); end
            for (int k = 0; k < 16; k++) begin
                n_cmp++;
                if (got_cyc[k] !== acc_cyc[0] + 1 + k) begin
                    n_bad++;
                    $display("FAIL single_latency idx %0d: got cycle %0d want %0d", k, got_cyc[k], acc_cyc[0] + 1 + k);
                end
            end
        end
        n_cmp++; if (frames_sent !== 16'd1) begin n_bad++; $display("FAIL single_frames_sent: got %0d want 1", frames_sent); end
    endtask

    task automatic test_exhaustive();
        logic [15:0] fb = frames_sent;
        tx_msgs = '{64'hFEDCBA9876543210, 64'h0123456789ABCDEF,
                    {$urandom, $urandom}, {$urandom, $urandom}};
        build_expected();
        run_stream(100);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL exh_timeout: got %0d bytes want 64", got_data.size()); end
        for (int k = 0; k < exp_word.size(); k++) begin
            logic [12:0] obs = (k < got_data.size()) ? {got_data[k], got_idx[k], got_last[k]} : 13'bx;
            n_cmp++;
            if (obs !== exp_word[k]) begin
                n_bad++;
                $display("FAIL exh_byte %0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         k, obs[12:5], obs[4:1], obs[0], exp_word[k][12:5], exp_word[k][4:1], exp_word[k][0]);
            end
        end
        for (int k = 0; k < got_data.size(); k++) begin
            n_cmp++;
            if ($countones(got_data[k]) % 2 != 0) begin
                n_bad++; $display("FAIL exh_weight byte %0d: got %h odd weight want even", k, got_data[k]);
            end
            for (int b = 0; b < 8; b++) begin
                n_cmp++;
                if (ref_syndrome(got_data[k] ^ (8'h01 << b)) == 4'h0) begin
                    n_bad++; $display("FAIL exh_flip byte %0d bit %0d: got syndrome 0 want nonzero", k, b);
                end
            end
        end
        n_cmp++; if (frames_sent - fb !== 16'd4) begin n_bad++; $display("FAIL exh_frames: got %0d want 4", frames_sent - fb); end
    endtask

    task automatic test_backpressure();
        logic [15:0] fb = frames_sent;
        tx_msgs = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        build_expected();
        run_stream(50);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got %0d bytes want 48", got_data.size()); end
        for (int k = 0; k < exp_word.size(); k++) begin
            logic [12:0] obs = (k < got_data.size()) ? {got_data[k], got_idx[k], got_last[k]} : 13'bx;
            n_cmp++;
            if (obs !== exp_word[k]) begin
                n_bad++;
                $display("FAIL bp_byte %0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         k, obs[12:5], obs[4:1], obs[0], exp_word[k][12:5], exp_word[k][4:1], exp_word[k][0]);
            end
        end
        n_cmp++; if (stall_changes !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_changes); end
        n_cmp++; if (frames_sent - fb !== 16'd3) begin n_bad++; $display("FAIL bp_frames: got %0d want 3", frames_sent - fb); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] fb = frames_sent;
        tx_msgs = '{{$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF};
        build_expected();
        run_stream(100);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: got %0d bytes want 32", got_data.size()); end
        for (int k = 0; k < exp_word.size(); k++) begin
            logic [12:0] obs = (k < got_data.size()) ? {got_data[k], got_idx[k], got_last[k]} : 13'bx;
            n_cmp++;
            if (obs !== exp_word[k]) begin
                n_bad++;
                $display("FAIL b2b_byte %0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         k, obs[12:5], obs[4:1], obs[0], exp_word[k][12:5], exp_word[k][4:1], exp_word[k][0]);
            end
        end
        if (got_data.size() >= 32 && acc_cyc.size() >= 2) begin
            n_cmp++; if (acc_cyc[1] !== got_cyc[15]) begin n_bad++; $display("FAIL b2b_accept: got cycle %0d want %0d", acc_cyc[1], got_cyc[15]); end
            n_cmp++; if (got_cyc[16] !== got_cyc[15] + 1) begin n_bad++; $display("FAIL b2b_bubble: got cycle %0d want %0d", got_cyc[16], got_cyc[15] + 1); end
            n_cmp++; if (got_data[16] !== 8'hFF) begin n_bad++; $display("FAIL b2b_first: got %h want FF", got_data[16]); end
            n_cmp++; if (got_cyc[31] - got_cyc[0] !== 31) begin n_bad++; $display("FAIL b2b_span: got %0d want 31", got_cyc[31] - got_cyc[0]); end
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL b2b_count: got %0d bytes %0d accepts want 32 and 2", got_data.size(), acc_cyc.size());
        end
        n_cmp++; if (frames_sent - fb !== 16'd2) begin n_bad++; $display("FAIL b2b_frames: got %0d want 2", frames_sent - fb); end
    endtask

    task automatic test_reset_midframe();
        int cyc = 0;
        int spurious = 0;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_message = {$urandom, $urandom};
        bus.out_ready  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        while (!(bus.out_valid === 1'b1 && bus.out_idx === 4'd6) && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_cmp++; if (cyc >= 100) begin n_bad++; $display("FAIL rst_mid_reach: got no idx 6 within %0d cycles want idx 6", cyc); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_mid_data: got %h want 00", bus.out_data); end
        n_cmp++; if (bus.out_idx !== 4'd0) begin n_bad++; $display("FAIL rst_mid_idx: got %0d want 0", bus.out_idx); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL rst_mid_last: got %b want 0", bus.out_last); end
        n_cmp++; if (frames_sent !== 16'd0) begin n_bad++; $display("FAIL rst_mid_frames: got %0d want 0", frames_sent); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (bus.out_valid !== 1'b0) spurious++;
        end
        n_cmp++; if (spurious !== 0) begin n_bad++; $display("FAIL rst_mid_resume: got %0d valid cycles want 0", spurious); end
        tx_msgs = '{{$urandom, $urandom}};
        build_expected();
        run_stream(100);
        for (int k = 0; k < exp_word.size(); k++) begin
            logic [12:0] obs = (k < got_data.size()) ? {got_data[k], got_idx[k], got_last[k]} : 13'bx;
            n_cmp++;
            if (obs !== exp_word[k]) begin
                n_bad++;
                $display("FAIL rst_mid_byte %0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                         k, obs[12:5], obs[4:1], obs[0], exp_word[k][12:5], exp_word[k][4:1], exp_word[k][0]);
            end
        end
        n_cmp++; if (frames_sent !== 16'd1) begin n_bad++; $display("FAIL rst_mid_frames_after: got %0d want 1", frames_sent); end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_seq[5];
        int  k = 0;
        int  cyc = 0;
        bit  pending = 1'b0;
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
        n_cmp++; if (frames_w !== 2'd0) begin n_bad++; $display("FAIL wrap_start: got %0d want 0", frames_w); end
        @(negedge clk);
        wbus.in_valid   = 1'b1;
        wbus.in_message = {$urandom, $urandom};
        wbus.out_ready  = 1'b1;
        while (k < 5 && cyc < 400) begin
            #1;
            if (pending) begin
                n_cmp++;
                if (frames_w !== exp_seq[k]) begin
                    n_bad++; $display("FAIL wrap_frame %0d: got %0d want %0d", k + 1, frames_w, exp_seq[k]);
                end
                k++;
                pending = 1'b0;
            end
            if (wbus.out_valid && wbus.out_ready && wbus.out_last) pending = 1'b1;
            @(negedge clk);
            cyc++;
        end
        wbus.in_valid = 1'b0;
        n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL wrap_timeout: got %0d frames want 5", k); end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_message  = 64'h0;
        bus.out_ready   = 1'b0;
        wbus.in_valid   = 1'b0;
        wbus.in_message = 64'h0;
        wbus.out_ready  = 1'b0;
        test_reset();
        test_single_frame();
        test_exhaustive();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hamming_frame_encoder.md
# hamming_frame_encoder

Upstream stage of the Hamming SECDED link. It accepts a 64-bit message over a valid/ready handshake and splits it into 16 nibbles. Each nibble is encoded into one 8-bit Hamming(8,4) SECDED codeword. The codewords are streamed one byte per handshake to the channel/error-injection stage, which feeds the 16-codeword decoder.

## Interface
Parameters:
- NIBBLES, 16: codewords per frame; message width is 4*NIBBLES.
- CNT_W, 16: width of the frames_sent counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: message offered.
- in_ready, output, 1: encoder can accept a message.
- in_message, input, 64: message; nibble k = in_message[4k+3:4k].
- out_valid, output, 1: out_data holds a valid codeword.
- out_ready, input, 1: downstream accepts the codeword.
- out_data, output, 8: SECDED codeword.
- out_idx, output, 4: nibble index of out_data (0..15).
- out_last, output, 1: high with out_idx == NIBBLES-1.
- frames_sent, output, CNT_W: count of completed frames; wraps modulo 2^CNT_W.

## Operation
- Codeword bit layout: bit i = Hamming position i, for i in 1..7, and bit 0 = overall parity.
  - Data: d1 = nib[0] at pos 3, d2 = nib[1] at pos 5, d3 = nib[2] at pos 6, d4 = nib[3] at pos 7.
  - Check bits: p1 = d1^d2^d4 (pos 1), p2 = d1^d3^d4 (pos 2), p4 = d2^d3^d4 (pos 4).
  - Overall parity: bit 0 = XOR of bits 7..1, so every codeword has even weight.
- FSM has two states, IDLE and SEND.
  - IDLE: in_ready = 1. On in_valid, latch in_message into msg_q, set nibble counter to 0, and go to SEND.
  - SEND: out_valid = 1, out_data = encode(msg_q nibble cnt), out_idx = cnt.
    - On out_valid && out_ready with cnt < NIBBLES-1: cnt increments.
    - On the handshake with cnt == NIBBLES-1: frames_sent increments. The FSM returns to IDLE unless a new message is accepted in the same cycle.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). The path from out_ready to in_ready is combinational.
- Simultaneous last-byte handshake and new acceptance: the FSM stays in SEND with cnt = 0 and the new msg_q. There is no bubble cycle.
- In SEND with no acceptance pending, in_valid is ignored. The message is not latched and the upstream holds it.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable.
- Reset mid-frame: the frame is aborted with no continuation after release. frames_sent is not incremented for it.

## Timing
- Reset values:
  - out_valid = 0, out_data = 8'h00, out_idx = 0, out_last = 0, frames_sent = 0.
  - State = IDLE, so in_ready = 1.
- Latency: message accepted at edge N gives codeword 0 valid after edge N (registered outputs).
- With out_ready held high, codeword k is valid in cycle N+1+k.
- Throughput: 16 cycles per frame sustained with back-to-back messages; 17 cycles with one IDLE gap.
- out_data, out_idx, out_last and out_valid are all registered; none depend combinationally on inputs.

## Structure
- Package hamming_pkg:
  - NIBBLES and CW_W = 8.
  - Bit-position constants for the layout above.
  - Function encode84(nib) -> [7:0].
  - The decoder shares this package for its syndrome map.
- Sub-module hamming84_enc: purely combinational 4-to-8 encoder, instanced once on the selected nibble.
- Top level: FSM, msg_q, cnt, output registers, frames_sent.

## Test plan
- Reset then single frame:
  - Stimulus: in_message = 64'h0123456789ABCDEF, out_ready = 1.
  - Response: bytes with idx 0..15 = FF, F0, ..., 0F, 00 (idx 0 = F -> 8'hFF, 1 = E -> 8'hF0, 14 = 1 -> 8'h0F, 15 = 0 -> 8'h00).
  - out_last only on idx 15; frames_sent = 1.
- Exhaustive nibble check:
  - Stimulus: messages covering every nibble value 0..F.
  - Response: each byte equals the reference model, has even weight, and any single-bit flip gives a nonzero syndrome.
- Backpressure:
  - Stimulus: out_ready random at 50%.
  - Response: out_data/out_idx stable while stalled; no byte skipped or duplicated; exactly 16 handshakes per frame.
- Back-to-back:
  - Stimulus: second message (64'hFFFF_FFFF_FFFF_FFFF) held valid.
  - Response: accepted on the idx 15 handshake; next cycle idx 0 = 8'hFF; 32 consecutive valid cycles; frames_sent = 2.
- Reset mid-frame:
  - Stimulus: assert rst_n low after idx 5.
  - Response: outputs go to reset values asynchronously; frames_sent = 0; after release, a new frame starts at idx 0.
- Counter wrap:
  - Stimulus: CNT_W = 2, 5 frames.
  - Response: frames_sent sequence 1, 2, 3, 0, 1.
